// File: rtl/keypad_entry_if.sv
// Scanner-side key inputs and display/entry outputs of the keypad entry block.
interface keypad_entry_if;
  logic       valid;
  logic [3:0] code;
  logic       key_strobe;
  logic [3:0] key_code;
  logic [2:0] count;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output valid,
    output code,
    input  key_strobe,
    input  key_code,
    input  count,
    input  an,
    input  seg
  );

  modport slave (
    input  valid,
    input  code,
    output key_strobe,
    output key_code,
    output count,
    output an,
    output seg
  );
endinterface

// File: rtl/keypad_entry_display.sv
// Debounces keypad scanner output into one event per press, keeps the last four keys and
// drives them onto a multiplexed common-anode 7-segment display.
module keypad_entry_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SCAN_DIV        = 1000
) (
  input logic           clk,
  input logic           reset,
  keypad_entry_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} state_e;

  localparam logic [7:0]  DbLimit  = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] ScanLast = 16'(SCAN_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic       valid_s1_q, valid_s2_q;
  logic [3:0] code_s1_q, code_s2_q;

  state_e     state_q, state_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [3:0] pc_q, pc_d;
  logic       accept;

  logic            key_strobe_q;
  logic [3:0]      key_code_q;
  logic [2:0]      count_q;
  logic [3:0][3:0] digit_q;

  logic [15:0] scnt_q;
  logic [1:0]  si_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  // Valid/Code arrive from another timing domain in effect; two flops before any use.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
      code_s1_q  <= 4'h0;
      code_s2_q  <= 4'h0;
    end else begin
      valid_s1_q <= bus.valid;
      valid_s2_q <= valid_s1_q;
      code_s1_q  <= bus.code;
      code_s2_q  <= code_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dcnt_q  <= 8'd0;
      pc_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pc_d    = pc_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_s2_q) begin
          pc_d    = code_s2_q;
          dcnt_d  = 8'd1;
          state_d = StPress;
        end
      end
      StPress: begin
        if (!valid_s2_q || (code_s2_q != pc_q)) begin
          state_d = StIdle;
        end else if (dcnt_q == DbLimit) begin
          accept  = 1'b1;
          state_d = StHeld;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      StHeld: begin
        if (!valid_s2_q) begin
          dcnt_d  = 8'd1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Code changes during a bounce back to high are ignored: still the same press.
        if (valid_s2_q) begin
          state_d = StHeld;
        end else if (dcnt_q == DbLimit) begin
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_strobe_q <= 1'b0;
      key_code_q   <= 4'h0;
      count_q      <= 3'd0;
      digit_q      <= '0;
    end else begin
      key_strobe_q <= accept;
      if (accept) begin
        key_code_q <= pc_q;
        digit_q    <= {digit_q[2:0], pc_q};
        if (count_q != 3'd4) begin
          count_q <= count_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q <= 16'd0;
      si_q   <= 2'd0;
    end else if (scnt_q == ScanLast) begin
      scnt_q <= 16'd0;
      si_q   <= si_q + 2'd1;
    end else begin
      scnt_q <= scnt_q + 16'd1;
    end
  end

  // Positions not yet entered stay dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
    end else if ({1'b0, si_q} < count_q) begin
      an_q  <= ~(4'b0001 << si_q);
      seg_q <= hex7(digit_q[si_q]);
    end else begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
    end
  end

  assign bus.key_strobe = key_strobe_q;
  assign bus.key_code   = key_code_q;
  assign bus.count      = count_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Randomized and directed stimulus; expected key events go to a scoreboard that a
// strobe monitor drains, and the display is checked against a model of entered keys.
module tb_keypad_entry_display;
  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;
  localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_entry_if bus ();

  keypad_entry_display #(
    .DEBOUNCE_CYCLES(D),
    .SCAN_DIV       (SD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  code;
    logic [2:0]  count;
    int unsigned at;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  logic [3:0]  entered[$];
  exp_t        mon_e;
  logic        prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int unsigned model_count();
    return (entered.size() > 4) ? 4 : entered.size();
  endfunction

  function automatic logic [3:0] model_digit(int unsigned pos);
    return (pos < entered.size()) ? entered[entered.size() - 1 - pos] : 4'h0;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expected key.
  always @(negedge clk) begin
    if (bus.key_strobe) begin
      check("strobe_spacing", prev_strobe, 0);
      check("strobe_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("key_code", bus.key_code, mon_e.code);
        check("count", bus.count, mon_e.count);
        check("strobe_cycle", cyc, mon_e.at);
      end
    end
    prev_strobe = bus.key_strobe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // first_edge: cycle number of the first posedge that samples Valid high.
  task automatic expect_key(input logic [3:0] c, input int unsigned first_edge);
    entered.push_back(c);
    sb.push_back('{code: c, count: 3'(model_count()), at: first_edge + D + 2});
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap);
    bus.code  = c;
    bus.valid = 1'b1;
    expect_key(c, cyc + 1);
    step(hold);
    bus.valid = 1'b0;
    bus.code  = 4'($urandom);
    step(gap);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, bus.key_strobe, 0);
    check({tag, "_key_code"}, bus.key_code, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_an"}, bus.an, 4'hF);
    check({tag, "_seg"}, bus.seg, 7'h7F);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    entered.delete();
  endtask

  // One full rotation: each entered position lit once with its digit, others dark.
  task automatic check_display();
    logic [3:0]  lit = 4'h0;
    int unsigned pos;
    check("disp_count", bus.count, model_count());
    for (int i = 0; i < int'(4 * SD); i++) begin
      if (bus.an == 4'hF) begin
        check("dark_seg", bus.seg, 7'h7F);
      end else begin
        check("an_onehot", $countones(~bus.an), 1);
        pos = 0;
        for (int b = 0; b < 4; b++) if (!bus.an[b]) pos = b;
        lit[pos] = 1'b1;
        check("lit_entered", (pos < model_count()), 1);
        check("seg_digit", bus.seg, HEX7[model_digit(pos)]);
      end
      step(1);
    end
    check("lit_positions", lit, (4'h1 << model_count()) - 4'h1);
  endtask

  int          r;
  logic [3:0]  c;
  int          hold;
  int unsigned t0;
  logic [3:0]  prev_an;
  bit          found;
  logic [10:0] exp_scan;

  initial begin
    bus.valid = 1'b0;
    bus.code  = 4'h0;
    step(1);
    apply_reset();

    // Short pulses and a code toggling faster than the debounce window.
    bus.code  = 4'h2;
    bus.valid = 1'b1;
    step(3);
    bus.valid = 1'b0;
    step(D + 3);
    bus.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.code = 4'h3;
      step(2);
      bus.code = 4'h4;
      step(2);
    end
    bus.valid = 1'b0;
    step(D + 6);
    check("glitch_count", bus.count, 0);

    press(4'h5, 20, 15);
    drain();
    check("single_press_count", bus.count, 1);

    // Overflow past four digits.
    apply_reset();
    press(4'h1, 8, 8);
    press(4'h2, 8, 8);
    press(4'h3, 8, 8);
    press(4'h4, 8, 8);
    press(4'hA, 8, 8);
    drain();
    check_display();

    // Scan pattern with two digits.
    apply_reset();
    press(4'h8, 8, 8);
    press(4'hF, 8, 8);
    drain();
    found   = 1'b0;
    prev_an = bus.an;
    for (int n = 0; n < 64 && !found; n++) begin
      step(1);
      if (bus.an == 4'hE && prev_an != 4'hE) found = 1'b1;
      else prev_an = bus.an;
    end
    check("scan_found", found, 1);
    for (int i = 0; i < 16; i++) begin
      if (i < 4) exp_scan = {4'hE, 7'h0E};
      else if (i < 8) exp_scan = {4'hD, 7'h00};
      else exp_scan = {4'hF, 7'h7F};
      check("scan_seq", {bus.an, bus.seg}, exp_scan);
      step(1);
    end
    check_display();

    // Release bounce stays a single press.
    apply_reset();
    bus.code  = 4'h9;
    bus.valid = 1'b1;
    expect_key(4'h9, cyc + 1);
    step(12);
    bus.valid = 1'b0;
    step(2);
    bus.valid = 1'b1;
    step(1);
    bus.valid = 1'b0;
    step(10);
    drain();

    // Reset during debounce of a held key; the key is debounced afresh afterwards.
    apply_reset();
    bus.code  = 4'h7;
    bus.valid = 1'b1;
    t0 = cyc;
    step(4);
    reset = 1'b1;
    step(1);
    check_reset_outputs("midpress");
    reset = 1'b0;
    entered.delete();
    expect_key(4'h7, t0 + 6);
    step(15);
    bus.valid = 1'b0;
    step(D + 4);
    drain();

    // Randomized presses, glitches, bounces and code changes while held.
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      c = 4'($urandom);
      if (r < 3) begin
        bus.code  = c;
        bus.valid = 1'b1;
        step($urandom_range(1, D));
        bus.valid = 1'b0;
        step($urandom_range(2, D + 4));
      end else begin
        bus.code  = c;
        bus.valid = 1'b1;
        expect_key(c, cyc + 1);
        hold = $urandom_range(D + 4, D + 12);
        if (r >= 8) begin
          step(D + 4);
          bus.code = 4'($urandom);
          step(hold - int'(D) - 4);
        end else begin
          step(hold);
        end
        if (r == 5 || r == 9) begin
          bus.valid = 1'b0;
          step($urandom_range(1, D));
          bus.valid = 1'b1;
          step($urandom_range(1, 3));
        end
        bus.valid = 1'b0;
        bus.code  = 4'($urandom);
        step($urandom_range(D + 2, D + 6));
      end
    end
    drain();
    check_display();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
